// File: rtl/internal_cell_q.sv
// Parametrised fixed-point internal cell of the Gaussian-elimination systolic array.
// Multiply-add/swap with load/pass modes, valid bubbles and sticky saturation.
module internal_cell_q #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       operation,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             s_in,
    output logic [WIDTH-1:0] c_out,
    output logic             s_out,
    output logic             cs_valid_out,
    output logic [WIDTH-1:0] x_out,
    output logic             x_valid_out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_NONPIV = 2'b00,
        OP_NBPIV  = 2'b01,
        OP_LOAD   = 2'b10,
        OP_PASS   = 2'b11
    } op_e;

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW:0] SMAX =
        {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] SMIN =
        {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    op_e op;
    assign op = op_e'(operation);

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] c_q;
    logic             s_q;
    logic             csv_q;
    logic             ovf_q;

    logic                 sw;
    logic [WIDTH-1:0]     w1, w2;
    logic signed [PW-1:0] c_ext, w1_ext, prod, shifted;
    logic signed [PW:0]   sum;
    logic [WIDTH-1:0]     res_d;
    logic                 clamp_d;

    always_comb begin
        sw      = (op == OP_NBPIV) && s_in;
        w1      = sw ? x_in : p_q;
        w2      = sw ? p_q : x_in;
        c_ext   = {{WIDTH{c_in[WIDTH-1]}}, c_in};
        w1_ext  = {{WIDTH{w1[WIDTH-1]}}, w1};
        prod    = c_ext * w1_ext;
        shifted = prod >>> FRAC;
        // Widened by one bit so the add can never wrap before clamping.
        sum     = {shifted[PW-1], shifted}
                + {{(WIDTH + 1){w2[WIDTH-1]}}, w2};
        res_d   = x_in;
        p_d     = p_q;
        clamp_d = 1'b0;
        unique case (op)
            OP_NONPIV, OP_NBPIV: begin
                p_d = sw ? x_in : p_q;
                if (sum > SMAX) begin
                    res_d   = SMAX[WIDTH-1:0];
                    clamp_d = 1'b1;
                end else if (sum < SMIN) begin
                    res_d   = SMIN[WIDTH-1:0];
                    clamp_d = 1'b1;
                end else begin
                    res_d = sum[WIDTH-1:0];
                end
            end
            OP_LOAD: begin
                p_d = x_in;
            end
            OP_PASS: begin
                p_d = p_q;
            end
        endcase
    end

    logic [WIDTH-1:0] x_q [LAT];
    logic             v_q [LAT];
    logic             o_q [LAT];
    logic [WIDTH-1:0] x_d [LAT];
    logic             v_d [LAT];
    logic             o_d [LAT];

    always_comb begin
        x_d[0] = res_d;
        v_d[0] = valid_in;
        o_d[0] = clamp_d;
        for (int k = 1; k < LAT; k++) begin
            x_d[k] = x_q[k-1];
            v_d[k] = v_q[k-1];
            o_d[k] = o_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            c_q   <= '0;
            s_q   <= 1'b0;
            csv_q <= 1'b0;
            ovf_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                x_q[k] <= '0;
                v_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
            end
        end else begin
            csv_q <= valid_in;
            if (valid_in) begin
                p_q <= p_d;
                c_q <= c_in;
                s_q <= s_in;
            end
            for (int k = 0; k < LAT; k++) begin
                v_q[k] <= v_d[k];
                if (v_d[k]) begin
                    x_q[k] <= x_d[k];
                    o_q[k] <= o_d[k];
                end
            end
            // Flag rises together with the clamped value reaching x_out.
            if (v_d[LAT-1] && o_d[LAT-1]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign c_out        = c_q;
    assign s_out        = s_q;
    assign cs_valid_out = csv_q;
    assign x_out        = x_q[LAT-1];
    assign x_valid_out  = v_q[LAT-1];
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_internal_cell_q.sv
// Scoreboard bench for internal_cell_q across four parameter sets
// sharing one stimulus stream.
module tb_internal_cell_q;

    localparam int NI = 4;

    function automatic int w_of(input int g);
        return (g == 3) ? 16 : 32;
    endfunction
    function automatic int f_of(input int g);
        return (g == 3) ? 8 : 16;
    endfunction
    function automatic int l_of(input int g);
        case (g)
            0: return 2;
            1: return 1;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    typedef struct {
        longint val;
        bit     ovf;
        int     due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  opr;
    logic        vin;
    logic        sin;
    logic [31:0] c32, x32, c16, x16;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    logic [31:0] xo_a [NI];
    logic [31:0] co_a [NI];
    logic [31:0] pq_a [NI];
    logic        xv_a [NI];
    logic        ov_a [NI];
    logic        so_a [NI];
    logic        cv_a [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = w_of(g);
        localparam int F = f_of(g);
        localparam int L = l_of(g);

        logic [W-1:0] cin_l, xin_l, cout_l, xout_l;
        logic         xv_l, so_l, cv_l, ov_l;

        assign cin_l = (W == 32) ? c32[W-1:0] : c16[W-1:0];
        assign xin_l = (W == 32) ? x32[W-1:0] : x16[W-1:0];

        internal_cell_q #(.WIDTH(W), .FRAC(F), .LAT(L)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .operation    (opr),
            .valid_in     (vin),
            .c_in         (cin_l),
            .x_in         (xin_l),
            .s_in         (sin),
            .c_out        (cout_l),
            .s_out        (so_l),
            .cs_valid_out (cv_l),
            .x_out        (xout_l),
            .x_valid_out  (xv_l),
            .ovf          (ov_l)
        );

        assign xo_a[g] = 32'($signed(xout_l));
        assign co_a[g] = 32'($signed(cout_l));
        assign pq_a[g] = 32'($signed(u_dut.p_q));
        assign xv_a[g] = xv_l;
        assign ov_a[g] = ov_l;
        assign so_a[g] = so_l;
        assign cv_a[g] = cv_l;

        exp_t         q[$];
        longint       mp;
        bit           movf;
        logic [W-1:0] cexp;
        logic         sexp;
        logic         cvexp;

        initial begin
            mp    = 0;
            movf  = 0;
            cexp  = '0;
            sexp  = 1'b0;
            cvexp = 1'b0;
        end

        always @(posedge clk) begin : model
            longint c, x, r, w1, w2, mx, mn;
            bit     sw, sat;
            if (rst) begin
                q.delete();
                mp    = 0;
                movf  = 0;
                cexp  = '0;
                sexp  = 1'b0;
                cvexp = 1'b0;
            end else begin
                cvexp = vin;
                if (vin) begin
                    cexp = cin_l;
                    sexp = sin;
                    c    = longint'($signed(cin_l));
                    x    = longint'($signed(xin_l));
                    mx   = (longint'(1) << (W - 1)) - 1;
                    mn   = -mx - 1;
                    r    = x;
                    sat  = 0;
                    if (opr == 2'b00 || opr == 2'b01) begin
                        sw = (opr == 2'b01) && sin;
                        w1 = sw ? x : mp;
                        w2 = sw ? mp : x;
                        r  = ((c * w1) >>> F) + w2;
                        if (r > mx) begin
                            r   = mx;
                            sat = 1;
                        end else if (r < mn) begin
                            r   = mn;
                            sat = 1;
                        end
                        if (sat) movf = 1;
                        if (sw) mp = x;
                    end else if (opr == 2'b10) begin
                        mp = x;
                    end
                    q.push_back('{r, movf, ecnt + L});
                end
            end
        end

        always @(negedge clk) begin : monitor
            exp_t e;
            checks++;
            if (cv_l !== cvexp || cout_l !== cexp || so_l !== sexp) begin
                errors++;
                $display("FAIL cs[%0d] got v=%b c=%h s=%b exp v=%b c=%h s=%b",
                         g, cv_l, cout_l, so_l, cvexp, cexp, sexp);
            end
            if (q.size() > 0 && q[0].due < ecnt) begin
                checks++;
                errors++;
                $display("FAIL xlat[%0d] got no valid by edge %0d exp valid at %0d",
                         g, ecnt, q[0].due);
                e = q.pop_front();
            end
            if (xv_l === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL xstale[%0d] got valid x=%h exp no valid",
                             g, xout_l);
                end else begin
                    e = q.pop_front();
                    if (longint'($signed(xout_l)) !== e.val ||
                        ecnt != e.due || ov_l !== e.ovf) begin
                        errors++;
                        $display("FAIL xout[%0d] got x=%h edge=%0d ovf=%b exp x=%h edge=%0d ovf=%b",
                                 g, xout_l, ecnt, ov_l, e.val, e.due, e.ovf);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [1:0] o, input logic v, input logic s,
                       input logic [31:0] ca, input logic [31:0] xa,
                       input logic [31:0] cb, input logic [31:0] xb);
        opr = o;
        vin = v;
        sin = s;
        c32 = ca;
        x32 = xa;
        c16 = cb;
        x16 = xb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (xo_a[i] !== 0 || xv_a[i] !== 0 || ov_a[i] !== 0 ||
                pq_a[i] !== 0 || co_a[i] !== 0 || so_a[i] !== 0 ||
                cv_a[i] !== 0) begin
                errors++;
                $display("FAIL %s[%0d] got x=%h xv=%b ovf=%b p=%h c=%h s=%b cv=%b exp all 0",
                         tag, i, xo_a[i], xv_a[i], ov_a[i], pq_a[i],
                         co_a[i], so_a[i], cv_a[i]);
            end
        end
    endtask

    task automatic check_p(input string tag, input logic [31:0] e32,
                           input logic [31:0] e16);
        logic [31:0] e;
        for (int i = 0; i < NI; i++) begin
            e = (i == 3) ? e16 : e32;
            checks++;
            if (pq_a[i] !== e) begin
                errors++;
                $display("FAIL %s[%0d] got p=%h exp p=%h", tag, i, pq_a[i], e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vin = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_zero("reset");
        rst = 1'b0;
        vin = 1'b0;
    endtask

    task automatic test_load_nonpivot();
        cyc(2'b10, 1, 0, 32'h0, 32'h00020000, 32'h0, 32'h0200);
        cyc(2'b00, 1, 0, 32'h00008000, 32'h00030000, 32'h0080, 32'h0300);
        idle(6);
        check_p("load_p", 32'h00020000, 32'hFFFF_FFFF & 32'h0200);
    endtask

    task automatic test_pivot();
        cyc(2'b10, 1, 0, 32'h0, 32'h00020000, 32'h0, 32'h0200);
        cyc(2'b01, 1, 1, 32'hFFFF0000, 32'h00050000, 32'h0000FF00, 32'h0500);
        idle(6);
        check_p("swap_p", 32'h00050000, 32'h0500);
        cyc(2'b01, 1, 0, 32'hFFFF0000, 32'h00050000, 32'h0000FF00, 32'h0500);
        cyc(2'b00, 1, 1, 32'hFFFF0000, 32'h00050000, 32'h0000FF00, 32'h0500);
        idle(6);
        check_p("noswap_p", 32'h00050000, 32'h0500);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ov_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL ovf_pre[%0d] got %b exp 0", i, ov_a[i]);
            end
        end
        cyc(2'b10, 1, 0, 32'h0, 32'h7FFF0000, 32'h0, 32'h7F00);
        cyc(2'b00, 1, 0, 32'h00020000, 32'h00010000, 32'h0200, 32'h0100);
        cyc(2'b00, 1, 0, 32'h00008000, 32'h00010000, 32'h0080, 32'h0100);
        cyc(2'b00, 1, 0, 32'hFFFE0000, 32'h00010000, 32'h0000FE00, 32'h0100);
        cyc(2'b00, 1, 0, 32'h00008000, 32'h00010000, 32'h0080, 32'h0100);
        idle(6);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ov_a[i] !== 1'b1) begin
                errors++;
                $display("FAIL ovf_sticky[%0d] got %b exp 1", i, ov_a[i]);
            end
        end
    endtask

    task automatic test_bubbles_pass();
        cyc(2'b11, 1, 0, 32'h0, 32'h1, 32'h0, 32'h1);
        cyc(2'b11, 0, 0, 32'h0, 32'h2, 32'h0, 32'h2);
        cyc(2'b11, 1, 1, 32'h5, 32'h3, 32'h5, 32'h3);
        cyc(2'b11, 1, 0, 32'h6, 32'h4, 32'h6, 32'h4);
        idle(6);
        check_p("pass_p", 32'h7FFF0000, 32'h7F00);
    endtask

    task automatic test_reset_mid();
        cyc(2'b00, 1, 0, 32'h00010000, 32'h00010000, 32'h0100, 32'h0100);
        cyc(2'b10, 1, 0, 32'h00010000, 32'h00030000, 32'h0100, 32'h0300);
        rst = 1'b1;
        cyc(2'b00, 1, 1, 32'h00010000, 32'h00010000, 32'h0100, 32'h0100);
        rst = 1'b0;
        vin = 1'b0;
        check_zero("rst_mid");
        idle(8);
        check_zero("rst_drain");
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2, r3;
        for (int n = 0; n < 300; n++) begin
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            cyc(r3[1:0], r3[4:2] != 3'b000, r3[5],
                {{12{r1[31]}}, r1[19:0]},
                r3[6] ? r2 : {{8{r2[31]}}, r2[23:0]},
                {16'h0, r1[31:28], r1[11:0]},
                {16'h0, r2[15:0]});
        end
        idle(8);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        opr = 2'b00;
        vin = 1'b0;
        sin = 1'b0;
        c32 = '0;
        x32 = '0;
        c16 = '0;
        x16 = '0;
        test_reset();
        test_load_nonpivot();
        test_pivot();
        test_saturation();
        test_bubbles_pass();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
